// File: rtl/fighter_pkg.sv
// Shared encodings and default frame constants for the fighter player blocks.
package fighter_pkg;

  localparam int CNT_W               = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 250000;
  localparam int ATTACK_FRAMES_DEF   = 12;
  localparam int STUN_FRAMES_DEF     = 20;

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ATTACK = 2'd1;
  localparam logic [1:0] ST_STUN   = 2'd2;

  function automatic logic rising(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; a new level is accepted only after
// DEBOUNCE_CYCLES consecutive equal synchronised samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // cnt holds the number of differing samples already seen, so the last one lands on D-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/player_input_ctrl.sv
// Per-player input front end: debounce, SOCD resolve, jump/attack requests and the
// FREE/ATTACK/STUN action FSM. Optional macro INPUT_BUFFER_EN keeps one attack press buffered.
module player_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = fighter_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int ATTACK_FRAMES   = fighter_pkg::ATTACK_FRAMES_DEF,
  parameter int STUN_FRAMES     = fighter_pkg::STUN_FRAMES_DEF,
  parameter int CNT_W           = fighter_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_attack,
  input  logic       hit_taken,
  input  logic       jump_active,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       attack_start,
  output logic       move_enable,
  output logic [1:0] act_state
);
  import fighter_pkg::*;

  logic             left_db, right_db, jump_db, atk_db;
  logic             jump_db_q, atk_db_q;
  logic             jump_rise, atk_rise;
  logic             jump_pend, atk_pend;
  logic             in_free, atk_go;
  logic [1:0]       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left
    (.clk(clk), .reset(reset), .raw(btn_left),   .level(left_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right
    (.clk(clk), .reset(reset), .raw(btn_right),  .level(right_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_jump
    (.clk(clk), .reset(reset), .raw(btn_jump),   .level(jump_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_attack
    (.clk(clk), .reset(reset), .raw(btn_attack), .level(atk_db));

  assign jump_rise = rising(jump_db, jump_db_q);
  assign atk_rise  = rising(atk_db, atk_db_q);
  assign in_free   = (state == ST_FREE);
  // hit_taken outranks attack entry, so it also suppresses the start pulse
  assign atk_go       = SCEN & in_free & atk_pend & ~jump_active & ~hit_taken;
  assign attack_start = atk_go;
  assign jump         = jump_pend;
  assign act_state    = state;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (hit_taken) begin
      next_state = ST_STUN;
      next_cnt   = '0;
    end else if (SCEN) begin
      case (state)
        ST_FREE: begin
          if (atk_pend && !jump_active) begin
            next_state = ST_ATTACK;
            next_cnt   = '0;
          end
        end
        ST_ATTACK: begin
          if (cnt == CNT_W'(ATTACK_FRAMES - 1)) begin
            next_state = ST_FREE;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + CNT_W'(1);
          end
        end
        ST_STUN: begin
          if (cnt == CNT_W'(STUN_FRAMES - 1)) begin
            next_state = ST_FREE;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + CNT_W'(1);
          end
        end
        default: begin
          next_state = ST_FREE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FREE;
      cnt         <= '0;
      move_enable <= 1'b1;
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      jump_db_q   <= 1'b0;
      atk_db_q    <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      move_enable <= (next_state == ST_FREE);
      move_left   <= left_db & ~right_db;
      move_right  <= right_db & ~left_db;
      jump_db_q   <= jump_db;
      atk_db_q    <= atk_db;
    end
  end

  // A press that lands on the serving SCEN edge is kept for the following frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jump_pend <= 1'b0;
    end else if (hit_taken) begin
      jump_pend <= 1'b0;
    end else if (jump_pend && SCEN) begin
      jump_pend <= 1'b0;
    end else if (jump_rise && in_free && !jump_active) begin
      jump_pend <= 1'b1;
    end
  end

`ifdef INPUT_BUFFER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      atk_pend <= 1'b0;
    end else if (atk_rise) begin
      atk_pend <= 1'b1;
    end else if (atk_go) begin
      atk_pend <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      atk_pend <= 1'b0;
    end else if (!in_free) begin
      atk_pend <= 1'b0;
    end else if (atk_rise) begin
      atk_pend <= 1'b1;
    end else if (atk_go) begin
      atk_pend <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed and randomized bench for player_input_ctrl with a stable-window button model.
module tb_player_input_ctrl;

  localparam int DB = 4;
  localparam int AF = 3;
  localparam int SF = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SCEN = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_attack = 1'b0;
  logic hit_taken = 1'b0, jump_active = 1'b0;
  logic move_left, move_right, jump, attack_start, move_enable;
  logic [1:0] act_state;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit model_on = 1'b0;
  bit q_l[$];
  bit q_r[$];
  bit lvl_l, lvl_r, exp_ml, exp_mr;

  always #5 clk = ~clk;

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(DB), .ATTACK_FRAMES(AF), .STUN_FRAMES(SF), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .SCEN(SCEN),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_attack(btn_attack),
    .hit_taken(hit_taken), .jump_active(jump_active),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .attack_start(attack_start), .move_enable(move_enable), .act_state(act_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Level becomes v once the last DB synchronised samples (two edges old) all equal v.
  function automatic bit settle(input bit cur, input bit is_right);
    bit v;
    bit same;
    same = 1'b1;
    v = is_right ? q_r[$-2] : q_l[$-2];
    for (int j = 3; j <= DB + 1; j++)
      if ((is_right ? q_r[$-j] : q_l[$-j]) != v) same = 1'b0;
    return same ? v : cur;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (model_on) begin
      q_l.push_back(btn_left);
      q_r.push_back(btn_right);
      if (q_l.size() > 32) begin
        q_l.delete(0);
        q_r.delete(0);
      end
      exp_ml = lvl_l & ~lvl_r;
      exp_mr = lvl_r & ~lvl_l;
      lvl_l = settle(lvl_l, 1'b0);
      lvl_r = settle(lvl_r, 1'b1);
      chk("model_left", move_left, exp_ml);
      chk("model_right", move_right, exp_mr);
    end
    SCEN = (cyc % 8 == 7);
    #1;
  endtask

  task automatic next_scen();
    int n;
    n = 0;
    while (!SCEN && n < 20) begin
      tick();
      n++;
    end
    chk("scen_wait", SCEN, 1);
  endtask

  task automatic wait_attack_start(input int limit, output bit seen);
    int n;
    n = 0;
    seen = attack_start;
    while (!seen && n < limit) begin
      tick();
      seen = attack_start;
      n++;
    end
  endtask

  task automatic wait_free(input string tag);
    int n;
    n = 0;
    while (act_state != 2'd0 && n < 80) begin
      tick();
      n++;
    end
    chk(tag, act_state, 0);
  endtask

  initial begin
    bit seen;
    bit exp_buf;
    int n_srv, n_rise, n_high;
    logic prev;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_move_enable", move_enable, 1);
    chk("rst_act_state", act_state, 0);
    chk("rst_outputs", {move_left, move_right, jump, attack_start}, 0);
    reset = 1'b0;
    for (int i = 0; i < DB + 2; i++) begin
      q_l.push_back(1'b0);
      q_r.push_back(1'b0);
    end
    lvl_l = 1'b0;
    lvl_r = 1'b0;
    model_on = 1'b1;
    tick();

    // glitch then a proper hold
    btn_left = 1'b1;
    repeat (3) tick();
    btn_left = 1'b0;
    repeat (10) tick();
    chk("glitch_left", move_left, 0);
    btn_left = 1'b1;
    repeat (6) tick();
    chk("left_before_latency", move_left, 0);
    tick();
    chk("left_at_latency", move_left, 1);

    // SOCD
    btn_right = 1'b1;
    repeat (8) tick();
    chk("socd_left", move_left, 0);
    chk("socd_right", move_right, 0);
    btn_left = 1'b0;
    repeat (8) tick();
    chk("socd_release_left", move_left, 0);
    chk("socd_release_right", move_right, 1);
    btn_right = 1'b0;
    repeat (8) tick();
    chk("right_released", move_right, 0);

    // jump: one serve per press, blocked while airborne
    btn_jump = 1'b1;
    n_srv = 0;
    n_rise = 0;
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (jump && SCEN) n_srv++;
      if (jump && !prev) n_rise++;
      prev = jump;
    end
    chk("jump_served_once", n_srv, 1);
    chk("jump_rose_once", n_rise, 1);
    chk("jump_low_after", jump, 0);
    btn_jump = 1'b0;
    repeat (10) tick();
    jump_active = 1'b1;
    btn_jump = 1'b1;
    n_high = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (jump) n_high++;
    end
    chk("jump_blocked_airborne", n_high, 0);
    btn_jump = 1'b0;
    repeat (10) tick();
    jump_active = 1'b0;

    // attack from FREE
    btn_attack = 1'b1;
    wait_attack_start(30, seen);
    chk("atk_start_seen", seen, 1);
    chk("atk_start_on_scen", SCEN, 1);
    chk("atk_from_free", act_state, 0);
    tick();
    chk("atk_entered", act_state, 1);
    chk("atk_locked", move_enable, 0);
    for (int i = 1; i <= AF; i++) begin
      next_scen();
      chk("atk_lock_frame", move_enable, 0);
      tick();
      chk("atk_state_frame", act_state, (i < AF) ? 1 : 0);
    end
    chk("atk_unlocked", move_enable, 1);
    btn_attack = 1'b0;
    repeat (20) tick();
    chk("atk_no_retrigger", act_state, 0);

    // hit during ATTACK cnt=1, re-hit at STUN cnt=3
    btn_attack = 1'b1;
    wait_attack_start(30, seen);
    chk("atk2_start_seen", seen, 1);
    btn_attack = 1'b0;
    tick();
    next_scen();
    tick();
    hit_taken = 1'b1;
    tick();
    hit_taken = 1'b0;
    chk("hit_to_stun", act_state, 2);
    chk("hit_locked", move_enable, 0);
    for (int i = 0; i < 3; i++) begin
      next_scen();
      tick();
    end
    chk("stun_mid", act_state, 2);
    hit_taken = 1'b1;
    tick();
    hit_taken = 1'b0;
    for (int i = 1; i <= SF; i++) begin
      next_scen();
      chk("stun_lock_frame", move_enable, 0);
      tick();
      chk("stun_state_frame", act_state, (i < SF) ? 2 : 0);
    end
    chk("stun_unlocked", move_enable, 1);

    // hit clears a pending jump
    next_scen();
    tick();
    tick();
    btn_jump = 1'b1;
    repeat (7) tick();
    chk("jump_pend_set", jump, 1);
    hit_taken = 1'b1;
    tick();
    hit_taken = 1'b0;
    chk("hit_clears_jump", jump, 0);
    chk("hit_from_free", act_state, 2);
    btn_jump = 1'b0;
    wait_free("jump_hit_recover");
    chk("jump_stays_clear", jump, 0);

    // attack pressed during STUN
    hit_taken = 1'b1;
    tick();
    hit_taken = 1'b0;
    next_scen();
    tick();
    next_scen();
    tick();
    btn_attack = 1'b1;
    repeat (10) tick();
    btn_attack = 1'b0;
    chk("buf_still_stun", act_state, 2);
    wait_free("buf_stun_end");
`ifdef INPUT_BUFFER_EN
    exp_buf = 1'b1;
`else
    exp_buf = 1'b0;
`endif
    wait_attack_start(10, seen);
    chk("buffered_attack", seen, exp_buf);
    tick();
    wait_free("buf_recover");

    // random left/right traffic against the window model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 3) == 0) btn_right = ~btn_right;
      tick();
    end
    btn_left = 1'b0;
    btn_right = 1'b0;
    repeat (10) tick();

    // reset aborts ATTACK immediately
    model_on = 1'b0;
    btn_attack = 1'b1;
    wait_attack_start(30, seen);
    chk("atk3_start_seen", seen, 1);
    btn_attack = 1'b0;
    tick();
    chk("atk3_entered", act_state, 1);
    reset = 1'b1;
    #1;
    chk("reset_abort_state", act_state, 0);
    chk("reset_abort_enable", move_enable, 1);
    chk("reset_abort_start", attack_start, 0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
